// File: rtl/accum5_pkg.sv
// Shared definitions for the accum5 stimulus sequencer: ALU mode codes, FSM states and
// the bit layout of an 18-bit program vector.
package accum5_pkg;

  localparam logic [3:0] MODE_ADD = 4'd0;
  localparam logic [3:0] MODE_SUB = 4'd1;
  localparam logic [3:0] MODE_CMP = 4'd2;
  localparam logic [3:0] MODE_AND = 4'd3;
  localparam logic [3:0] MODE_OR  = 4'd4;
  localparam logic [3:0] MODE_CPL = 4'd5;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCheck,
    StDone
  } seq_state_e;

  // Vector word: {a, b, m, cin, exp_r, exp_of}
  localparam int unsigned VecW     = 18;
  localparam int unsigned AOff     = 14;
  localparam int unsigned BOff     = 10;
  localparam int unsigned MOff     = 6;
  localparam int unsigned CinOff   = 5;
  localparam int unsigned ExpROff  = 1;
  localparam int unsigned ExpOfOff = 0;

endpackage

// File: rtl/accum5_prog_mem.sv
// Program store for the sequencer: DEPTH x 18-bit words, synchronous write, combinational read.
module accum5_prog_mem
  import accum5_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [VecW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [VecW-1:0]            rdata_o
);

  logic [VecW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/accum5_sequencer.sv
// Self-checking stimulus engine for the accum5 ALU: issues stored vectors and scores results.
// Build option: define ACCSEQ_STOP_ON_FAIL_EN to end a run at the first mismatch.
module accum5_sequencer
  import accum5_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LAT   = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       prog_we_i,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr_i,
  input  logic [VecW-1:0]            prog_data_i,
  input  logic                       start_i,
  input  logic [$clog2(DEPTH):0]     len_i,
  output logic [3:0]                 a_o,
  output logic [3:0]                 b_o,
  output logic [3:0]                 m_o,
  output logic                       cin_o,
  input  logic [3:0]                 r_i,
  input  logic                       of_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(DEPTH):0]     pass_cnt_o,
  output logic [$clog2(DEPTH):0]     fail_cnt_o,
  output logic                       err_valid_o,
  output logic [$clog2(DEPTH)-1:0]   err_idx_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [2:0]  WaitInit = 3'(LAT - 1);

  seq_state_e      state_q;
  logic [AW-1:0]   idx_q;
  logic [CW-1:0]   len_q;
  logic [2:0]      wcnt_q;
  logic [3:0]      a_q, b_q, m_q;
  logic            cin_q, busy_q, done_q, err_valid_q;
  logic [CW-1:0]   pass_q, fail_q;
  logic [AW-1:0]   err_idx_q;

  logic [VecW-1:0] vec;
  logic            mem_we, match, last, stop;

  // Writes are locked out while a run is reading the program.
  assign mem_we = prog_we_i && (state_q == StIdle);

  accum5_prog_mem #(
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (prog_addr_i),
    .wdata_i (prog_data_i),
    .raddr_i (idx_q),
    .rdata_o (vec)
  );

  assign match = (r_i == vec[ExpROff +: 4]) && (of_i == vec[ExpOfOff]);
  assign last  = ({1'b0, idx_q} == (len_q - CW'(1)));
`ifdef ACCSEQ_STOP_ON_FAIL_EN
  assign stop  = last || !match;
`else
  assign stop  = last;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      cin_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      err_valid_q <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q       <= len_i;
            pass_q      <= '0;
            fail_q      <= '0;
            err_valid_q <= 1'b0;
            err_idx_q   <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            if (len_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          a_q     <= vec[AOff +: 4];
          b_q     <= vec[BOff +: 4];
          m_q     <= vec[MOff +: 4];
          cin_q   <= vec[CinOff];
          wcnt_q  <= WaitInit;
          state_q <= StWait;
        end
        StWait: begin
          if (wcnt_q == 3'd0) begin
            state_q <= StCheck;
          end else begin
            wcnt_q <= wcnt_q - 3'd1;
          end
        end
        StCheck: begin
          if (match) begin
            pass_q <= pass_q + CW'(1);
          end else begin
            fail_q <= fail_q + CW'(1);
            if (!err_valid_q) begin
              err_valid_q <= 1'b1;
              err_idx_q   <= idx_q;
            end
          end
          if (stop) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + AW'(1);
            state_q <= StIssue;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign m_o         = m_q;
  assign cin_o       = cin_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_cnt_o  = pass_q;
  assign fail_cnt_o  = fail_q;
  assign err_valid_o = err_valid_q;
  assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_accum5_sequencer.sv
// Bench for accum5_sequencer: behavioural ALU with selectable settle delay, a run-level
// scoring model, directed program cases and randomized programs.
module tb_accum5_sequencer;
  import accum5_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int          SLOT  = LAT + 2;
`ifdef ACCSEQ_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [17:0]   prog_data = '0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [3:0]    a_o, b_o, m_o, r;
  logic          cin_o, of, busy_o, done_o, err_valid_o;
  logic [LW-1:0] pass_cnt_o, fail_cnt_o;
  logic [AW-1:0] err_idx_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] mirror [DEPTH];
  int e_pass, e_fail, e_errv, e_erri, e_nrun;

  int         alu_dly = LAT;
  logic [4:0] alu_pipe [8];

  always #5 clk = ~clk;

  accum5_sequencer #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .prog_we_i   (prog_we),
    .prog_addr_i (prog_addr),
    .prog_data_i (prog_data),
    .start_i     (start),
    .len_i       (len),
    .a_o         (a_o),
    .b_o         (b_o),
    .m_o         (m_o),
    .cin_o       (cin_o),
    .r_i         (r),
    .of_i        (of),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_cnt_o  (pass_cnt_o),
    .fail_cnt_o  (fail_cnt_o),
    .err_valid_o (err_valid_o),
    .err_idx_o   (err_idx_o)
  );

  // Returns {r, of}.
  function automatic logic [4:0] alu_fn(input logic [3:0] fa, input logic [3:0] fb,
                                        input logic [3:0] fm, input logic fc);
    logic [4:0] s;
    case (fm)
      MODE_ADD: s = {1'b0, fa} + {1'b0, fb} + {4'd0, fc};
      MODE_SUB: s = {1'b0, fa} - {1'b0, fb} - {4'd0, fc};
      MODE_CMP: s = {2'b00, fa > fb, fa == fb, fa < fb};
      MODE_AND: s = {1'b0, fa & fb};
      MODE_OR:  s = {1'b0, fa | fb};
      MODE_CPL: s = {1'b0, ~fa};
      default:  s = 5'd0;
    endcase
    return {s[3:0], s[4]};
  endfunction

  function automatic logic [17:0] mkvec(input logic [3:0] fa, input logic [3:0] fb,
                                        input logic [3:0] fm, input logic fc);
    return {fa, fb, fm, fc, alu_fn(fa, fb, fm, fc)};
  endfunction

  // ALU settles alu_dly cycles after its operands change.
  always_ff @(posedge clk) begin
    alu_pipe[0] <= alu_fn(a_o, b_o, m_o, cin_o);
    for (int i = 1; i < 8; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign r  = alu_pipe[alu_dly-1][4:1];
  assign of = alu_pipe[alu_dly-1][0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // A stale ALU (one cycle slower than LAT) shows the previous operand set's result in CHECK.
  task automatic model(input int n, input bit stale, input logic [12:0] prev);
    logic [12:0] ops;
    logic [4:0]  obs;
    e_pass = 0; e_fail = 0; e_errv = 0; e_erri = 0; e_nrun = 0;
    for (int j = 0; j < n; j++) begin
      ops = stale ? ((j == 0) ? prev : mirror[j-1][17:5]) : mirror[j][17:5];
      obs = alu_fn(ops[12:9], ops[8:5], ops[4:1], ops[0]);
      e_nrun++;
      if (obs == mirror[j][4:0]) begin
        e_pass++;
      end else begin
        e_fail++;
        if (e_errv == 0) begin
          e_errv = 1;
          e_erri = j;
        end
        if (StopOnFail) break;
      end
    end
  endtask

  task automatic write_word(input int addr, input logic [17:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = AW'(addr); prog_data = d;
    mirror[addr] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int n, input bit stale, input bit disturb,
                         input bit wr, input int wr_addr, input logic [17:0] wr_data);
    int cyc;
    logic [12:0] prev;
    prev = {a_o, b_o, m_o, cin_o};
    @(negedge clk);
    start = 1'b1; len = LW'(n);
    if (wr) begin
      prog_we = 1'b1; prog_addr = AW'(wr_addr); prog_data = wr_data;
      mirror[wr_addr] = wr_data;
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    model(n, stale, prev);
    cyc = 1;
    check_eq({tag, ".busy"}, 32'(busy_o), 1);
    while (!done_o && cyc < 400) begin
      if (disturb && cyc == 2) begin
        start = 1'b1; len = LW'(3);
        prog_we = 1'b1; prog_addr = '0; prog_data = '1;
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      if (((cyc - 1) % SLOT) != 0 && ((cyc - 1) / SLOT) < e_nrun)
        check_eq({tag, ".ops"}, 32'({a_o, b_o, m_o, cin_o}), 32'(mirror[(cyc-1)/SLOT][17:5]));
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; prog_we = 1'b0;
    check_eq({tag, ".done_cyc"}, cyc, e_nrun * SLOT + 1);
    check_eq({tag, ".pass"}, 32'(pass_cnt_o), e_pass);
    check_eq({tag, ".fail"}, 32'(fail_cnt_o), e_fail);
    check_eq({tag, ".errv"}, 32'(err_valid_o), e_errv);
    if (e_errv != 0) check_eq({tag, ".erri"}, 32'(err_idx_o), e_erri);
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, 32'(done_o), 0);
    check_eq({tag, ".busy_end"}, 32'(busy_o), 0);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, ".ops"}, 32'({a_o, b_o, m_o, cin_o}), 0);
    check_eq({tag, ".flags"}, 32'({busy_o, done_o, err_valid_o}), 0);
    check_eq({tag, ".cnts"}, 32'({pass_cnt_o, fail_cnt_o, err_idx_o}), 0);
  endtask

  initial begin
    logic [17:0] v;
    int cyc;
    int n;

    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    write_word(0, mkvec(4'hF, 4'h1, MODE_ADD, 1'b0));
    run_seq("single_add", 1, 1'b0, 1'b0, 1'b0, 0, '0);

    write_word(1, mkvec(4'hF, 4'h9, MODE_SUB, 1'b0));
    write_word(2, mkvec(4'h7, 4'hC, MODE_AND, 1'b0));
    write_word(3, mkvec(4'hA, 4'h5, MODE_OR,  1'b0));
    write_word(4, mkvec(4'h3, 4'h3, MODE_CMP, 1'b0));
    write_word(5, mkvec(4'h5, 4'h0, MODE_CPL, 1'b1));
    run_seq("mixed_disturb", 6, 1'b0, 1'b1, 1'b0, 0, '0);
    run_seq("mem_intact", 6, 1'b0, 1'b0, 1'b0, 0, '0);

    v = mirror[2]; v[4:1] = v[4:1] ^ 4'h1; write_word(2, v);
    v = mirror[4]; v[4:1] = v[4:1] ^ 4'h8; write_word(4, v);
    run_seq("inject", 6, 1'b0, 1'b0, 1'b0, 0, '0);
    write_word(2, mkvec(4'h7, 4'hC, MODE_AND, 1'b0));
    write_word(4, mkvec(4'h3, 4'h3, MODE_CMP, 1'b0));

    // Reset during the WAIT of vector 3.
    @(negedge clk);
    start = 1'b1; len = LW'(6);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 3 * SLOT + 2) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    check_cleared("mid_reset");
    reset = 1'b0;
    run_seq("after_reset", 6, 1'b0, 1'b0, 1'b0, 0, '0);

    run_seq("len0", 0, 1'b0, 1'b0, 1'b0, 0, '0);

    alu_dly = LAT + 1;
    run_seq("slow_alu", 6, 1'b1, 1'b0, 1'b0, 0, '0);
    alu_dly = LAT;

    v = mkvec(4'h9, 4'h2, MODE_ADD, 1'b1); v[0] = ~v[0];
    run_seq("wr_with_start", 6, 1'b0, 1'b0, 1'b1, 5, v);

    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < DEPTH; j++) begin
        v = mkvec(4'($urandom), 4'($urandom), 4'($urandom_range(0, 5)), 1'($urandom));
        if ($urandom_range(0, 3) == 0) v[4:1] = v[4:1] ^ 4'($urandom_range(1, 15));
        write_word(j, v);
      end
      n = $urandom_range(1, DEPTH);
      run_seq("random", n, 1'b0, 1'b0, 1'b0, 0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
